// File: rtl/vector_store_serializer.sv
// vector_store_serializer: writes the masked lanes of a packed vector result to memory, one lane per accepted write
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       store request valid
//   in_ready       block can accept a request (IDLE only)
//   in_data        packed vector, lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
//   in_base_addr   address of lane 0; lane i is always written to base+i
//   in_lane_mask   1 = store lane i
//   mem_we         write request, held with address/data until mem_ready
//   mem_addr       write address (wraps modulo 2^ADDR_WIDTH)
//   mem_wdata      write data
//   mem_ready      memory accepts the write this cycle
//   busy           high in STORE or DONE
//   done           one-cycle completion pulse
//   err            stall-timeout pulse, coincident with done
//
// Optional feature: define VSTORE_TIMEOUT_EN to abandon a request after
// 255 consecutive stalled write cycles; otherwise err is tied low.
module vector_store_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 6,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH*LANES-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0]       in_base_addr,
  input  logic [LANES-1:0]            in_lane_mask,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic                        mem_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  typedef enum logic [1:0] {IDLE, STORE, DONE} state_t;
  state_t                        state_q;
  logic [DATA_WIDTH*LANES-1:0]   data_q;
  logic [ADDR_WIDTH-1:0]         base_q;
  logic [LANES-1:0]              mask_q;
  logic [IW-1:0]                 idx_q;
  logic                          in_ready_q;
  logic                          mem_we_q;
  logic [ADDR_WIDTH-1:0]         mem_addr_q;
  logic [DATA_WIDTH-1:0]         mem_wdata_q;
  logic                          busy_q;
  logic                          done_q;
  logic [LANES-1:0]              rem_d;
  logic [LANES-1:0]              nxt_mask_d;
  logic [DATA_WIDTH*LANES-1:0]   nxt_data_d;
  logic [ADDR_WIDTH-1:0]         nxt_base_d;
  logic [IW-1:0]                 nxt_idx_d;
  logic [DATA_WIDTH-1:0]         nxt_wdata_d;
  logic [ADDR_WIDTH-1:0]         nxt_addr_d;
`ifdef VSTORE_TIMEOUT_EN
  logic [7:0]                    stall_q;
  logic                          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  // Next lane to present: from the incoming request while idle, otherwise
  // from the captured request with the lane just written removed. Scanning
  // high-to-low leaves the lowest set bit selected.
  always_comb begin
    rem_d       = mask_q & ~(LANES'(1) << idx_q);
    nxt_mask_d  = (state_q == IDLE) ? in_lane_mask : rem_d;
    nxt_data_d  = (state_q == IDLE) ? in_data : data_q;
    nxt_base_d  = (state_q == IDLE) ? in_base_addr : base_q;
    nxt_idx_d   = '0;
    nxt_wdata_d = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (nxt_mask_d[i]) begin
        nxt_idx_d   = IW'(i);
        nxt_wdata_d = nxt_data_d[i*DATA_WIDTH +: DATA_WIDTH];
      end
    nxt_addr_d = nxt_base_d + ADDR_WIDTH'(nxt_idx_d);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      base_q      <= '0;
      mask_q      <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef VSTORE_TIMEOUT_EN
      stall_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else
      case (state_q)
        IDLE:
          if (in_valid && in_ready_q) begin
            data_q     <= in_data;
            base_q     <= in_base_addr;
            mask_q     <= in_lane_mask;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef VSTORE_TIMEOUT_EN
            stall_q    <= '0;
`endif
            if (|in_lane_mask) begin
              state_q     <= STORE;
              idx_q       <= nxt_idx_d;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= nxt_addr_d;
              mem_wdata_q <= nxt_wdata_d;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        STORE:
          if (mem_ready) begin
            mask_q <= rem_d;
`ifdef VSTORE_TIMEOUT_EN
            stall_q <= '0;
`endif
            if (|rem_d) begin
              idx_q       <= nxt_idx_d;
              mem_addr_q  <= nxt_addr_d;
              mem_wdata_q <= nxt_wdata_d;
            end else begin
              state_q  <= DONE;
              mem_we_q <= 1'b0;
              done_q   <= 1'b1;
            end
          end
`ifdef VSTORE_TIMEOUT_EN
          // This stalled cycle brings the counter to 255: give up.
          else if (stall_q == 8'd254) begin
            stall_q  <= 8'd255;
            state_q  <= DONE;
            mem_we_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
          end else
            stall_q <= stall_q + 8'd1;
`endif
        DONE: begin
          state_q    <= IDLE;
          done_q     <= 1'b0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
`ifdef VSTORE_TIMEOUT_EN
          err_q      <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
endmodule
